rng_state_bank: RTL and testbench

Multi-context successor of the single-context RNG byte-state register. It holds NUM_CTX independent RNG states of NUM_BYTES bytes each, all in flip-flops.
- Direct port: byte-masked parallel writes into any context.
- Seed port: a serial, byte-at-a-time seed load into one context, with a valid/ready handshake and per-context "seeded" status.
- Read port: registered, whole-state read of a selected context.
The bank sits between the seed source (TRNG/host) and the RNG cores, which read and update their state through the direct ports.

---
 rtl/rng_pkg.sv | 17 +
 rtl/rng_seed_loader.sv | 88 ++++++++
 rtl/rng_state_bank.sv | 92 +++++++++
 tb/tb_rng_state_bank.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared definitions for the RNG state bank: seed FSM encoding, byte width, and
// the index-width helper.
package rng_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        SEED_IDLE = 1'b0,
        SEED_LOAD = 1'b1
    } seed_state_e;

    // clog2 with a minimum of 1, so that single-entry ranges still get a usable index bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rng_seed_loader.sv
// Serial seed loader: IDLE/LOAD FSM with valid/ready handshake, byte index counter,
// done pulse, and per-context seeded flags. Emits one byte write request per cycle.
module rng_seed_loader
    import rng_pkg::*;
#(
    parameter  int unsigned NUM_BYTES = 32,
    parameter  int unsigned NUM_CTX   = 4,
    localparam int unsigned CTX_W     = clog2_min1(NUM_CTX),
    localparam int unsigned IDX_W     = clog2_min1(NUM_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [CTX_W-1:0]  i_ctx,
    input  logic              i_abort,
    input  logic              i_valid,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_busy,
    output logic              o_done,
    output logic [NUM_CTX-1:0] o_seeded,
    output logic              o_we,
    output logic [CTX_W-1:0]  o_ctx,
    output logic [IDX_W-1:0]  o_idx,
    output logic [BYTE_W-1:0] o_byte
);

    seed_state_e        r_state;
    logic [CTX_W-1:0]   r_ctx;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;
    logic [NUM_CTX-1:0] r_seeded;

    logic w_start_ok;
    logic w_last;
    logic w_we;

    assign w_start_ok = i_start && (32'(i_ctx) < NUM_CTX);
    assign w_last     = (r_idx == IDX_W'(NUM_BYTES - 1));
    // Abort outranks a simultaneous valid byte, so it also suppresses the write.
    assign w_we       = (r_state == SEED_LOAD) && i_valid && !i_abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= SEED_IDLE;
            r_ctx    <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_seeded <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SEED_IDLE: begin
                    if (w_start_ok) begin
                        r_state          <= SEED_LOAD;
                        r_ctx            <= i_ctx;
                        r_idx            <= '0;
                        r_seeded[i_ctx]  <= 1'b0;
                    end
                end
                SEED_LOAD: begin
                    if (i_abort) begin
                        r_state <= SEED_IDLE;
                        r_idx   <= '0;
                    end else if (i_valid) begin
                        if (w_last) begin
                            r_state         <= SEED_IDLE;
                            r_idx           <= '0;
                            r_seeded[r_ctx] <= 1'b1;
                            r_done          <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= SEED_IDLE;
            endcase
        end
    end

    assign o_busy   = (r_state == SEED_LOAD);
    assign o_done   = r_done;
    assign o_seeded = r_seeded;
    assign o_we     = w_we;
    assign o_ctx    = r_ctx;
    assign o_idx    = r_idx;
    assign o_byte   = i_byte;

endmodule

// File: rtl/rng_state_bank.sv
// Multi-context RNG state bank: flip-flop context array with a byte-masked direct
// write port, a serial seed port, and a registered whole-state read port.
module rng_state_bank
    import rng_pkg::*;
#(
    parameter  int unsigned NUM_BYTES  = 32,
    parameter  int unsigned NUM_CTX    = 4,
    localparam int unsigned TOTAL_BITS = BYTE_W * NUM_BYTES,
    localparam int unsigned CTX_W      = clog2_min1(NUM_CTX),
    localparam int unsigned IDX_W      = clog2_min1(NUM_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [CTX_W-1:0]      wr_ctx,
    input  logic [NUM_BYTES-1:0]  wr_be,
    input  logic [TOTAL_BITS-1:0] wr_data,
    input  logic [CTX_W-1:0]      rd_ctx,
    output logic [TOTAL_BITS-1:0] rd_data,
    input  logic                  seed_start,
    input  logic [CTX_W-1:0]      seed_ctx,
    input  logic                  seed_abort,
    input  logic                  seed_valid,
    input  logic [BYTE_W-1:0]     seed_byte,
    output logic                  seed_ready,
    output logic                  seed_busy,
    output logic                  seed_done,
    output logic [NUM_CTX-1:0]    seeded
);

    logic [NUM_CTX-1:0][TOTAL_BITS-1:0] r_mem;
    logic [TOTAL_BITS-1:0]              r_rd_data;

    logic              w_seed_busy;
    logic              w_seed_we;
    logic [CTX_W-1:0]  w_seed_ctx;
    logic [IDX_W-1:0]  w_seed_idx;
    logic [BYTE_W-1:0] w_seed_byte;
    logic              w_wr_ok;

    rng_seed_loader #(
        .NUM_BYTES (NUM_BYTES),
        .NUM_CTX   (NUM_CTX)
    ) u_loader (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (seed_start),
        .i_ctx    (seed_ctx),
        .i_abort  (seed_abort),
        .i_valid  (seed_valid),
        .i_byte   (seed_byte),
        .o_busy   (w_seed_busy),
        .o_done   (seed_done),
        .o_seeded (seeded),
        .o_we     (w_seed_we),
        .o_ctx    (w_seed_ctx),
        .o_idx    (w_seed_idx),
        .o_byte   (w_seed_byte)
    );

    // The context being seeded is locked against direct writes for the whole load;
    // since busy is registered, the start edge itself still lets a direct write through.
    assign w_wr_ok = wr_en && (32'(wr_ctx) < NUM_CTX) &&
                     !(w_seed_busy && (wr_ctx == w_seed_ctx));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem     <= '0;
            r_rd_data <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CTX; c++) begin
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    if (w_seed_we && (w_seed_ctx == CTX_W'(c)) && (w_seed_idx == IDX_W'(i))) begin
                        r_mem[c][BYTE_W*i +: BYTE_W] <= w_seed_byte;
                    end else if (w_wr_ok && (wr_ctx == CTX_W'(c)) && wr_be[i]) begin
                        r_mem[c][BYTE_W*i +: BYTE_W] <= wr_data[BYTE_W*i +: BYTE_W];
                    end
                end
            end
            if (32'(rd_ctx) < NUM_CTX) begin
                r_rd_data <= r_mem[rd_ctx];
            end else begin
                r_rd_data <= '0;
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign seed_busy  = w_seed_busy;
    assign seed_ready = w_seed_busy;

endmodule

// File: tb/tb_rng_state_bank.sv
// Directed self-checking bench for rng_state_bank with NUM_BYTES=4, NUM_CTX=2.
module tb_rng_state_bank;

    localparam int unsigned NB = 4;
    localparam int unsigned NC = 2;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [0:0]  wr_ctx;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [0:0]  rd_ctx;
    logic [31:0] rd_data;
    logic        seed_start;
    logic [0:0]  seed_ctx;
    logic        seed_abort;
    logic        seed_valid;
    logic [7:0]  seed_byte;
    logic        seed_ready;
    logic        seed_busy;
    logic        seed_done;
    logic [1:0]  seeded;

    int unsigned checks = 0;
    int unsigned errors = 0;

    rng_state_bank #(
        .NUM_BYTES (NB),
        .NUM_CTX   (NC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_ctx     (wr_ctx),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .rd_ctx     (rd_ctx),
        .rd_data    (rd_data),
        .seed_start (seed_start),
        .seed_ctx   (seed_ctx),
        .seed_abort (seed_abort),
        .seed_valid (seed_valid),
        .seed_byte  (seed_byte),
        .seed_ready (seed_ready),
        .seed_busy  (seed_busy),
        .seed_done  (seed_done),
        .seeded     (seeded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seed_in(input logic [7:0] b);
        seed_valid = 1'b1;
        seed_byte  = b;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic read_ctx(input logic [0:0] c, input string tag, input logic [31:0] exp);
        rd_ctx = c;
        tick();
        check(tag, rd_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_ctx = '0; wr_be = '0; wr_data = '0;
        rd_ctx = '0; seed_start = 1'b0; seed_ctx = '0; seed_abort = 1'b0;
        seed_valid = 1'b0; seed_byte = '0;

        // 1. reset state
        tick(); tick();
        check("rst_rd", rd_data, 32'h0);
        check("rst_seeded", {30'd0, seeded}, 32'h0);
        check("rst_ready", {31'd0, seed_ready}, 32'h0);
        check("rst_busy", {31'd0, seed_busy}, 32'h0);
        check("rst_done", {31'd0, seed_done}, 32'h0);
        rst_n = 1'b1;
        read_ctx(1'b0, "rst_ctx0", 32'h0);
        read_ctx(1'b1, "rst_ctx1", 32'h0);

        // 2. byte-masked direct write
        wr_en = 1'b1; wr_ctx = 1'b1; wr_be = 4'b0101; wr_data = 32'hAABBCCDD;
        tick();
        wr_en = 1'b0;
        read_ctx(1'b1, "be_ctx1", 32'h00BB00DD);
        read_ctx(1'b0, "be_ctx0", 32'h0);

        // 3. seed ctx0 with a valid gap; seed_start during LOAD is ignored
        seed_start = 1'b1; seed_ctx = 1'b0;
        tick();
        seed_start = 1'b0;
        check("s3_busy", {31'd0, seed_busy}, 32'h1);
        check("s3_ready", {31'd0, seed_ready}, 32'h1);
        seed_in(8'h11);
        seed_in(8'h22);
        seed_start = 1'b1; seed_ctx = 1'b1;
        tick();
        seed_start = 1'b0;
        tick();
        check("s3_gap_done", {31'd0, seed_done}, 32'h0);
        check("s3_gap_busy", {31'd0, seed_busy}, 32'h1);
        seed_in(8'h33);
        check("s3_early_done", {31'd0, seed_done}, 32'h0);
        seed_in(8'h44);
        check("s3_done", {31'd0, seed_done}, 32'h1);
        check("s3_idle", {31'd0, seed_busy}, 32'h0);
        check("s3_seeded", {30'd0, seeded}, 32'h1);
        tick();
        check("s3_done_pulse", {31'd0, seed_done}, 32'h0);
        read_ctx(1'b0, "s3_ctx0", 32'h44332211);

        // 4. collisions: same-context direct write dropped, other context proceeds
        seed_start = 1'b1; seed_ctx = 1'b1;
        tick();
        seed_start = 1'b0;
        wr_en = 1'b1; wr_ctx = 1'b1; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
        seed_in(8'h01);
        wr_ctx = 1'b0; wr_data = 32'h12345678;
        seed_in(8'h02);
        wr_en = 1'b0;
        seed_in(8'h03);
        seed_in(8'h04);
        check("s4_done", {31'd0, seed_done}, 32'h1);
        check("s4_seeded", {30'd0, seeded}, 32'h3);
        read_ctx(1'b1, "s4_ctx1", 32'h04030201);
        read_ctx(1'b0, "s4_ctx0", 32'h12345678);

        // 5. abort after two bytes, abort beats a simultaneous valid byte
        seed_start = 1'b1; seed_ctx = 1'b1;
        tick();
        seed_start = 1'b0;
        check("s5_clr", {30'd0, seeded}, 32'h1);
        seed_in(8'h5A);
        seed_in(8'hA5);
        seed_abort = 1'b1;
        seed_in(8'hEE);
        seed_abort = 1'b0;
        check("s5_busy", {31'd0, seed_busy}, 32'h0);
        check("s5_done", {31'd0, seed_done}, 32'h0);
        check("s5_seeded", {30'd0, seeded}, 32'h1);
        read_ctx(1'b1, "s5_ctx1", 32'h0403A55A);

        // 6. reset mid-load, then a fresh start is accepted
        seed_start = 1'b1; seed_ctx = 1'b0;
        tick();
        seed_start = 1'b0;
        seed_in(8'h77);
        seed_in(8'h88);
        seed_in(8'h99);
        rst_n = 1'b0;
        tick();
        check("s6_busy", {31'd0, seed_busy}, 32'h0);
        check("s6_ready", {31'd0, seed_ready}, 32'h0);
        check("s6_seeded", {30'd0, seeded}, 32'h0);
        check("s6_rd", rd_data, 32'h0);
        rst_n = 1'b1;
        seed_start = 1'b1; seed_ctx = 1'b0;
        rd_ctx = 1'b1;
        tick();
        seed_start = 1'b0;
        check("s6_restart", {31'd0, seed_busy}, 32'h1);
        check("s6_ctx1", rd_data, 32'h0);
        read_ctx(1'b0, "s6_ctx0", 32'h0);
        seed_abort = 1'b1;
        tick();
        seed_abort = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
